hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed 5-stage hazard/forwarding unit. Replaces per-stage comparator chains with an in-flight producer shift register of depth DEPTH and per-entry Tnew countdown.
- Adds a cycle-counted MD busy tracker and a parametrised EPC-write → eret interlock.
- Sits beside the pipeline controller; drives stall/flush and forward selects for D- and E-stage operand muxes.

---
 rtl/hazard_scoreboard.sv | 154 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: in-flight producer shift register with per-slot Tnew countdown,
// youngest-match forwarding, HI/LO busy tracking and an EPC-write to eret interlock.
module hazard_scoreboard #(
    parameter int DEPTH       = 3,
    parameter int AW          = 5,
    parameter int TW          = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int EPC_SLOT    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic          d_we,
    input  logic [AW-1:0] d_waddr,
    input  logic [TW-1:0] d_tnew,
    input  logic [1:0]    d_md_op,
    input  logic          d_wr_epc,
    input  logic          d_is_eret,
    input  logic          flush_all,
    output logic          stall_F,
    output logic          stall_D,
    output logic          flush_E,
    output logic [2:0]    fwd_rs_D,
    output logic [2:0]    fwd_rt_D,
    output logic [2:0]    fwd_rs_E,
    output logic [2:0]    fwd_rt_E,
    output logic          md_busy
);
    localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW     = $clog2(MD_MAX + 1);

    logic [DEPTH:1]         vld_q, vld_d;
    logic [DEPTH:1]         epc_q, epc_d;
    logic [DEPTH:1][AW-1:0] waddr_q, waddr_d;
    logic [DEPTH:1][TW-1:0] tnew_q, tnew_d;
    logic [AW-1:0]          rs_e_q, rs_e_d, rt_e_q, rt_e_d;
    logic [CW-1:0]          md_cnt_q, md_cnt_d;

    logic          hit_rs_d, hit_rt_d, hit_rs_e, hit_rt_e;
    logic [2:0]    idx_rs_d, idx_rt_d, idx_rs_e, idx_rt_e;
    logic [TW-1:0] tn_rs_d, tn_rt_d, tn_rs_e, tn_rt_e;
    logic          epc_hit, stall, issue;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? t : t - TW'(1);
    endfunction

    // Scans oldest to youngest so the youngest matching slot overwrites earlier hits.
    function automatic void lookup(
        input  logic [AW-1:0]          addr,
        input  int                     lo,
        input  logic [DEPTH:1]         vld,
        input  logic [DEPTH:1][AW-1:0] wa,
        input  logic [DEPTH:1][TW-1:0] tn,
        output logic                   hit,
        output logic [2:0]             idx,
        output logic [TW-1:0]          tnew
    );
        hit  = 1'b0;
        idx  = '0;
        tnew = '0;
        for (int k = DEPTH; k >= lo; k--) begin
            if (vld[k] && wa[k] == addr && addr != '0) begin
                hit  = 1'b1;
                idx  = 3'(k);
                tnew = tn[k];
            end
        end
    endfunction

    always_comb begin
        lookup(d_rs,   1, vld_q, waddr_q, tnew_q, hit_rs_d, idx_rs_d, tn_rs_d);
        lookup(d_rt,   1, vld_q, waddr_q, tnew_q, hit_rt_d, idx_rt_d, tn_rt_d);
        lookup(rs_e_q, 2, vld_q, waddr_q, tnew_q, hit_rs_e, idx_rs_e, tn_rs_e);
        lookup(rt_e_q, 2, vld_q, waddr_q, tnew_q, hit_rt_e, idx_rt_e, tn_rt_e);

        epc_hit = 1'b0;
        for (int k = 1; k < EPC_SLOT; k++) begin
            if (k <= DEPTH) epc_hit = epc_hit | epc_q[k];
        end

        stall = d_valid & ((hit_rs_d && tn_rs_d > d_tuse_rs) ||
                           (hit_rt_d && tn_rt_d > d_tuse_rt) ||
                           (d_md_op != 2'd0 && md_busy) ||
                           (d_is_eret && epc_hit));
        issue = d_valid & ~stall;
    end

    assign stall_F  = stall;
    assign stall_D  = stall;
    assign flush_E  = stall;
    assign md_busy  = (md_cnt_q != '0);
    assign fwd_rs_D = (hit_rs_d && tn_rs_d == '0) ? idx_rs_d : 3'd0;
    assign fwd_rt_D = (hit_rt_d && tn_rt_d == '0) ? idx_rt_d : 3'd0;
    assign fwd_rs_E = (hit_rs_e && tn_rs_e == '0) ? idx_rs_e : 3'd0;
    assign fwd_rt_E = (hit_rt_e && tn_rt_e == '0) ? idx_rt_e : 3'd0;

    always_comb begin
        vld_d   = '0;
        epc_d   = '0;
        waddr_d = '0;
        tnew_d  = '0;
        for (int k = 2; k <= DEPTH; k++) begin
            vld_d[k]   = vld_q[k-1];
            epc_d[k]   = epc_q[k-1];
            waddr_d[k] = waddr_q[k-1];
            tnew_d[k]  = sat_dec(tnew_q[k-1]);
        end
        if (issue) begin
            vld_d[1]   = d_we & (d_waddr != '0);
            epc_d[1]   = d_wr_epc;
            waddr_d[1] = d_waddr;
            tnew_d[1]  = d_tnew;
        end
        if (flush_all) begin
            vld_d = '0;
            epc_d = '0;
        end

        rs_e_d = (issue && !flush_all) ? d_rs : '0;
        rt_e_d = (issue && !flush_all) ? d_rt : '0;

        // An issued MD op always runs to completion, so flush_all does not touch the counter.
        md_cnt_d = (md_cnt_q != '0) ? md_cnt_q - CW'(1) : md_cnt_q;
        if (issue && d_md_op == 2'd1) md_cnt_d = CW'(MULT_CYCLES);
        if (issue && d_md_op == 2'd2) md_cnt_d = CW'(DIV_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q    <= '0;
            epc_q    <= '0;
            rs_e_q   <= '0;
            rt_e_q   <= '0;
            md_cnt_q <= '0;
        end else begin
            vld_q    <= vld_d;
            epc_q    <= epc_d;
            rs_e_q   <= rs_e_d;
            rt_e_q   <= rt_e_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        tnew_q  <= tnew_d;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, branch, youngest-match, MD busy, EPC, flush, reset.
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_waddr;
    logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_we, d_wr_epc, d_is_eret, flush_all;
    logic [1:0] d_md_op;
    logic       stall_F, stall_D, flush_E, md_busy;
    logic [2:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_we(d_we), .d_waddr(d_waddr),
        .d_tnew(d_tnew), .d_md_op(d_md_op), .d_wr_epc(d_wr_epc), .d_is_eret(d_is_eret),
        .flush_all(flush_all), .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
        .md_busy(md_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_d();
        d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 0; d_tuse_rt = 0; d_we = 0;
        d_waddr = 0; d_tnew = 0; d_md_op = 0; d_wr_epc = 0; d_is_eret = 0;
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] urs,
                         input logic [2:0] urt, input logic we, input logic [4:0] wa,
                         input logic [2:0] tn, input logic [1:0] md, input logic epc,
                         input logic eret);
        d_valid = 1; d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt; d_we = we;
        d_waddr = wa; d_tnew = tn; d_md_op = md; d_wr_epc = epc; d_is_eret = eret;
        #1;
    endtask

    task automatic drain();
        clr_d();
        repeat (5) tick();
    endtask

    task automatic test_reset();
        reset = 1; flush_all = 0;
        clr_d();
        tick(); tick();
        reset = 0;
        #1;
        total++; if ({stall_F, stall_D, flush_E} !== 3'b000) begin bad++; $display("FAIL reset_stall got=%b want=000", {stall_F, stall_D, flush_E}); end
        total++; if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E} !== 12'd0) begin bad++; $display("FAIL reset_fwd got=%h want=000", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E}); end
        total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_md_busy got=%b want=0", md_busy); end
    endtask

    task automatic test_load_use();
        set_d(0, 0, 1, 1, 1, 8, 2, 0, 0, 0);          // lw $8
        total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL lu_lw_issue got=%b want=0", stall_D); end
        tick();
        set_d(8, 0, 1, 1, 1, 10, 1, 0, 0, 0);         // addu $10, $8, $0
        total++; if ({stall_F, stall_D, flush_E} !== 3'b111) begin bad++; $display("FAIL lu_stall got=%b want=111", {stall_F, stall_D, flush_E}); end
        tick();
        total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL lu_release got=%b want=0", stall_D); end
        total++; if (fwd_rs_D !== 3'd0) begin bad++; $display("FAIL lu_fwd_rs_D got=%0d want=0", fwd_rs_D); end
        tick();
        clr_d();
        total++; if (fwd_rs_E !== 3'd3) begin bad++; $display("FAIL lu_fwd_rs_E got=%0d want=3", fwd_rs_E); end
        total++; if (fwd_rt_E !== 3'd0) begin bad++; $display("FAIL lu_fwd_rt_E got=%0d want=0", fwd_rt_E); end
        drain();
    endtask

    task automatic test_branch();
        set_d(0, 0, 1, 1, 1, 9, 1, 0, 0, 0);          // addu $9
        tick();
        set_d(9, 0, 0, 0, 0, 0, 0, 0, 0, 0);          // beq $9, $0
        total++; if (stall_D !== 1'b1) begin bad++; $display("FAIL br_stall got=%b want=1", stall_D); end
        tick();
        total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL br_release got=%b want=0", stall_D); end
        total++; if (fwd_rs_D !== 3'd2) begin bad++; $display("FAIL br_fwd_rs_D got=%0d want=2", fwd_rs_D); end
        total++; if (fwd_rt_D !== 3'd0) begin bad++; $display("FAIL br_fwd_rt_D got=%0d want=0", fwd_rt_D); end
        tick();
        drain();
    endtask

    task automatic test_youngest();
        set_d(0, 0, 1, 1, 1, 5, 1, 0, 0, 0);          // older producer of $5
        tick();
        set_d(0, 0, 1, 1, 1, 5, 0, 0, 0, 0);          // younger producer of $5
        tick();
        set_d(5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (fwd_rs_D !== 3'd1) begin bad++; $display("FAIL yg_fwd_rs_D got=%0d want=1", fwd_rs_D); end
        total++; if (fwd_rt_D !== 3'd1) begin bad++; $display("FAIL yg_fwd_rt_D got=%0d want=1", fwd_rt_D); end
        total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL yg_stall got=%b want=0", stall_D); end
        tick();
        clr_d();
        total++; if (fwd_rs_E !== 3'd2) begin bad++; $display("FAIL yg_fwd_rs_E got=%0d want=2", fwd_rs_E); end
        drain();
    endtask

    task automatic test_md(input logic [1:0] op, input int cycles);
        int n;
        set_d(0, 0, 1, 1, 0, 0, 1, op, 0, 0);         // mult/div start
        tick();
        set_d(0, 0, 1, 1, 1, 2, 1, 3, 0, 0);          // mflo $2
        n = 0;
        while (stall_D === 1'b1 && n < 30) begin
            n++;
            tick();
        end
        total++; if (n != cycles) begin bad++; $display("FAIL md%0d_stall_cycles got=%0d want=%0d", op, n, cycles); end
        total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL md%0d_busy_end got=%b want=0", op, md_busy); end
        tick();
        clr_d();
        total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL md%0d_after_mflo got=%b want=0", op, md_busy); end
        drain();
    endtask

    task automatic test_epc();
        set_d(0, 0, 1, 1, 0, 0, 1, 0, 1, 0);          // mtc0 EPC
        tick();
        set_d(0, 0, 1, 1, 0, 0, 0, 0, 0, 1);          // eret
        total++; if (stall_D !== 1'b1) begin bad++; $display("FAIL epc_stall got=%b want=1", stall_D); end
        tick();
        total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL epc_release got=%b want=0", stall_D); end
        tick();
        drain();
    endtask

    task automatic test_flush();
        set_d(0, 0, 1, 1, 1, 8, 2, 0, 0, 0);          // lw $8
        tick();
        set_d(8, 0, 1, 1, 1, 11, 1, 0, 0, 0);
        flush_all = 1;
        #1;
        total++; if (stall_D !== 1'b1) begin bad++; $display("FAIL fl_stall_same_cycle got=%b want=1", stall_D); end
        tick();
        flush_all = 0;
        #1;
        total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL fl_stall_after got=%b want=0", stall_D); end
        total++; if (fwd_rs_D !== 3'd0) begin bad++; $display("FAIL fl_fwd_rs_D got=%0d want=0", fwd_rs_D); end
        total++; if (fwd_rs_E !== 3'd0) begin bad++; $display("FAIL fl_fwd_rs_E got=%0d want=0", fwd_rs_E); end
        tick();
        drain();
    endtask

    task automatic test_reset_md();
        set_d(0, 0, 1, 1, 0, 0, 1, 2, 0, 0);          // div start
        tick();
        clr_d();
        total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL rmd_busy got=%b want=1", md_busy); end
        reset = 1;
        tick();
        reset = 0;
        #1;
        total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL rmd_cleared got=%b want=0", md_busy); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_youngest();
        test_md(2'd2, 10);
        test_md(2'd1, 5);
        test_epc();
        test_flush();
        test_reset_md();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
